// File: rtl/duc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : duc_pkg
// Description : Shared constants and helpers for the DUC chain: settings
//               offsets, CIC geometry, unity scale value and the CIC gain
//               normalisation shift.
// Revision    : 1.0 - initial release
// ============================================================================
package duc_pkg;

  // Settings-bus offsets relative to BASE
  localparam logic [7:0] SR_PHASE_INC = 8'd0;
  localparam logic [7:0] SR_SCALE     = 8'd1;
  localparam logic [7:0] SR_RATE      = 8'd2;
  localparam logic [7:0] SR_SWAP      = 8'd3;

  // CIC geometry: stage count and internal bit growth
  localparam int CIC_N      = 4;
  localparam int CIC_GROWTH = 24;

  // Unity gain in the 18-bit signed scale register
  localparam int SCALE_ONE  = 16384;

  // Gain normalisation shift: 3 * ceil(log2 R), with rate 0 and 1 meaning R=1
  function automatic logic [4:0] cic_shift(input logic [7:0] rate);
    logic [8:0] r;
    logic [3:0] lg;
    r  = (rate <= 8'd1) ? 9'd1 : {1'b0, rate};
    lg = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if ((9'd1 << i) < r) lg = 4'(i + 1);
    end
    return 5'(3 * lg);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_interp.sv
`default_nettype none
// ============================================================================
// Module      : cic_interp
// Description : One real channel of the CIC interpolator: comb section at
//               the input sample rate, zero-stuffing, registered integrator
//               cascade at the output rate, and shift/saturate output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_interp
  import duc_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             comb_en,
  input  logic [WIDTH-1:0] din,
  input  logic [4:0]       shift,
  output logic [WIDTH-1:0] dout
);

  localparam int IW = WIDTH + CIC_GROWTH;

  logic signed [IW-1:0] comb_tap [CIC_N+1];
  logic signed [IW-1:0] comb_dly [CIC_N];
  logic signed [IW-1:0] comb_out;
  logic                 comb_vld;
  logic signed [IW-1:0] integ [CIC_N];
  logic signed [IW-1:0] integ_in;
  logic signed [IW-1:0] shifted;
  logic                 ovf;
  logic [WIDTH-1:0]     sat_val;

  // Comb chain is combinational; each stage subtracts its own previous input
  assign comb_tap[0] = {{CIC_GROWTH{din[WIDTH-1]}}, din};

  for (genvar k = 0; k < CIC_N; k++) begin : g_comb
    assign comb_tap[k+1] = comb_tap[k] - comb_dly[k];
  end

  // Comb section advances once per input sample and latches the difference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CIC_N; k++) comb_dly[k] <= '0;
      comb_out <= '0;
      comb_vld <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < CIC_N; k++) comb_dly[k] <= '0;
      comb_out <= '0;
      comb_vld <= 1'b0;
    end else begin
      comb_vld <= comb_en;
      if (comb_en) begin
        for (int k = 0; k < CIC_N; k++) comb_dly[k] <= comb_tap[k];
        comb_out <= comb_tap[CIC_N];
      end
    end
  end

  // Zero-stuffing: the comb result enters the integrators for one cycle only
  assign integ_in = comb_vld ? comb_out : '0;

  // Integrator cascade runs every cycle and wraps modulo 2^IW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CIC_N; k++) integ[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < CIC_N; k++) integ[k] <= '0;
    end else begin
      integ[0] <= integ[0] + integ_in;
      for (int k = 1; k < CIC_N; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Remove the R^(N-1) gain and clamp to the output width
  assign shifted = integ[CIC_N-1] >>> shift;
  assign ovf     = (shifted[IW-1:WIDTH-1] != {(IW-WIDTH+1){shifted[IW-1]}});
  assign sat_val = ovf ? {shifted[IW-1], {(WIDTH-1){~shifted[IW-1]}}}
                       : shifted[WIDTH-1:0];

  // Registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     dout <= '0;
    else if (flush) dout <= '0;
    else            dout <= sat_val;
  end

endmodule
`default_nettype wire

// File: rtl/duc_chain.sv
`default_nettype none
// ============================================================================
// Module      : duc_chain
// Description : TX digital up-conversion chain: settings registers, sample
//               strober, 18-bit complex scaling, two CIC interpolators and a
//               phase-aligned NCO phase export.
//               Optional build macro DUC_SWAP_IQ_EN adds the I/Q swap
//               register at BASE+3.
// Revision    : 1.0 - initial release
// ============================================================================
module duc_chain
  import duc_pkg::*;
#(
  parameter int BASE  = 0,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [31:0]      sample,
  input  logic             run,
  output logic             strobe,
  output logic [WIDTH-1:0] tx_fe_i,
  output logic [WIDTH-1:0] tx_fe_q,
  output logic [23:0]      phase_out
);

  localparam int                LAT     = 7;
  localparam int                SH      = 30 - WIDTH;
  localparam logic signed [33:0] RND    = 34'sd1 <<< (29 - WIDTH);
  localparam logic [7:0]        A_PHASE = 8'(BASE) + SR_PHASE_INC;
  localparam logic [7:0]        A_SCALE = 8'(BASE) + SR_SCALE;
  localparam logic [7:0]        A_RATE  = 8'(BASE) + SR_RATE;
`ifdef DUC_SWAP_IQ_EN
  localparam logic [7:0]        A_SWAP  = 8'(BASE) + SR_SWAP;
`endif

  logic [31:0]        phase_inc;
  logic signed [17:0] scale;
  logic [7:0]         rate;
`ifdef DUC_SWAP_IQ_EN
  logic               swap_iq;
`endif

  logic               flush;
  logic [7:0]         cnt;
  logic [7:0]         reload;
  logic               stb;
  logic               stb_d;
  logic signed [15:0] in_i, in_q;
  logic signed [33:0] prod_i, prod_q;
  logic [WIDTH-1:0]   scaled_i, scaled_q;
  logic [4:0]         shift;
  logic [31:0]        phase;
  logic [23:0]        phase_dly [LAT];

  // Round, shift down to WIDTH bits and saturate a scaled product
  function automatic logic [WIDTH-1:0] scale_sat(input logic signed [33:0] p);
    logic signed [33:0] r;
    r = (p + RND) >>> SH;
    if (r[33:WIDTH-1] != {(35-WIDTH){r[33]}})
      scale_sat = {r[33], {(WIDTH-1){~r[33]}}};
    else
      scale_sat = r[WIDTH-1:0];
  endfunction

  assign flush = ~run | clr;

  // Settings registers; only reset clears them, clr leaves them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_inc <= '0;
      scale     <= '0;
      rate      <= '0;
`ifdef DUC_SWAP_IQ_EN
      swap_iq   <= 1'b0;
`endif
    end else if (set_stb) begin
      if (set_addr == A_PHASE) phase_inc <= set_data;
      if (set_addr == A_SCALE) scale     <= set_data[17:0];
      if (set_addr == A_RATE)  rate      <= set_data[7:0];
`ifdef DUC_SWAP_IQ_EN
      if (set_addr == A_SWAP)  swap_iq   <= set_data[0];
`endif
    end
  end

  // Strober: fires whenever the down-counter sits at zero; held low in reset
  assign reload = (rate <= 8'd1) ? 8'd0 : rate - 8'd1;
  assign stb    = run & ~clr & rst_n & (cnt == 8'd0);
  assign strobe = stb;

  // Down-counter reloads R-1 on each strobe, so the current rate applies there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (flush)        cnt <= '0;
    else if (cnt == 8'd0)  cnt <= reload;
    else                   cnt <= cnt - 8'd1;
  end

`ifdef DUC_SWAP_IQ_EN
  assign in_i = swap_iq ? sample[15:0]  : sample[31:16];
  assign in_q = swap_iq ? sample[31:16] : sample[15:0];
`else
  assign in_i = sample[31:16];
  assign in_q = sample[15:0];
`endif

  assign prod_i = 34'(in_i) * 34'(scale);
  assign prod_q = 34'(in_q) * 34'(scale);

  // Scale stage captures a new sample on each strobe; stb_d drives the combs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scaled_i <= '0;
      scaled_q <= '0;
      stb_d    <= 1'b0;
    end else if (flush) begin
      scaled_i <= '0;
      scaled_q <= '0;
      stb_d    <= 1'b0;
    end else begin
      stb_d <= stb;
      if (stb) begin
        scaled_i <= scale_sat(prod_i);
        scaled_q <= scale_sat(prod_q);
      end
    end
  end

  assign shift = cic_shift(rate);

  cic_interp #(.WIDTH(WIDTH)) u_cic_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .comb_en (stb_d),
    .din     (scaled_i),
    .shift   (shift),
    .dout    (tx_fe_i)
  );

  cic_interp #(.WIDTH(WIDTH)) u_cic_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .comb_en (stb_d),
    .din     (scaled_q),
    .shift   (shift),
    .dout    (tx_fe_q)
  );

  // NCO accumulator plus a delay line matching the sample datapath latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      for (int k = 0; k < LAT; k++) phase_dly[k] <= '0;
    end else if (flush) begin
      phase <= '0;
      for (int k = 0; k < LAT; k++) phase_dly[k] <= '0;
    end else begin
      phase        <= phase + phase_inc;
      phase_dly[0] <= phase[31:8];
      for (int k = 1; k < LAT; k++) phase_dly[k] <= phase_dly[k-1];
    end
  end

  assign phase_out = phase_dly[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_duc_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_duc_chain
// Description : Directed self-checking bench for duc_chain (WIDTH=24, BASE=0)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_duc_chain;
  import duc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] sample;
  logic        run;
  logic        strobe;
  logic [23:0] tx_fe_i;
  logic [23:0] tx_fe_q;
  logic [23:0] phase_out;

  int checks;
  int failures;

  duc_chain #(.BASE(0), .WIDTH(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .sample    (sample),
    .run       (run),
    .strobe    (strobe),
    .tx_fe_i   (tx_fe_i),
    .tx_fe_q   (tx_fe_q),
    .phase_out (phase_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    step();
    set_stb  = 1'b0;
  endtask

  task automatic stop_run();
    run    = 1'b0;
    sample = '0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clr = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    run = 1'b1; sample = 32'h1234_5678;
    #1 rst_n = 1'b0;
    step(); step(); #1;
    checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", strobe); end
    checks++; if (tx_fe_i !== 24'h0) begin failures++; $display("FAIL reset_i got=%h exp=000000", tx_fe_i); end
    checks++; if (tx_fe_q !== 24'h0) begin failures++; $display("FAIL reset_q got=%h exp=000000", tx_fe_q); end
    checks++; if (phase_out !== 24'h0) begin failures++; $display("FAIL reset_phase got=%h exp=000000", phase_out); end
    run = 1'b0; sample = '0;
    step();
    rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_strober();
    logic e;
    wr(SR_RATE, 32'd5);
    run = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      e = (c % 5 == 0);
      checks++; if (strobe !== e) begin failures++; $display("FAIL strober c=%0d got=%b exp=%b", c, strobe, e); end
      step();
    end
    run = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL strober_off c=%0d got=%b exp=0", c, strobe); end
      step();
    end
  endtask

  task automatic test_impulse();
    logic [23:0] e;
    wr(SR_RATE, 32'd1);
    wr(SR_SCALE, 32'(SCALE_ONE));
    run = 1'b1;
    for (int c = 0; c < 15; c++) begin
      sample = (c == 0) ? 32'h1000_0000 : 32'h0;
      #1;
      e = (c == 7) ? 24'h100000 : 24'h0;
      checks++; if (strobe !== 1'b1) begin failures++; $display("FAIL impulse_strobe c=%0d got=%b exp=1", c, strobe); end
      checks++; if (tx_fe_i !== e) begin failures++; $display("FAIL impulse_i c=%0d got=%h exp=%h", c, tx_fe_i, e); end
      checks++; if (tx_fe_q !== 24'h0) begin failures++; $display("FAIL impulse_q c=%0d got=%h exp=000000", c, tx_fe_q); end
      step();
    end
    stop_run();
  endtask

  task automatic test_step();
    logic e;
    wr(SR_RATE, 32'd4);
    run = 1'b1; sample = 32'h1000_0000;
    for (int c = 0; c < 40; c++) begin
      #1;
      e = (c % 4 == 0);
      checks++; if (strobe !== e) begin failures++; $display("FAIL step_strobe c=%0d got=%b exp=%b", c, strobe, e); end
      if (c >= 24) begin
        checks++; if (tx_fe_i !== 24'h100000) begin failures++; $display("FAIL step_i c=%0d got=%h exp=100000", c, tx_fe_i); end
        checks++; if (tx_fe_q !== 24'h0) begin failures++; $display("FAIL step_q c=%0d got=%h exp=000000", c, tx_fe_q); end
      end
      step();
    end
    stop_run();
  endtask

  task automatic test_rounding();
    wr(SR_RATE, 32'd1);
    wr(SR_SCALE, 32'd1);
    run = 1'b1; sample = {16'd32, 16'd31};
    for (int c = 0; c < 10; c++) step();
    checks++; if (tx_fe_i !== 24'h000001) begin failures++; $display("FAIL round_pos_i got=%h exp=000001", tx_fe_i); end
    checks++; if (tx_fe_q !== 24'h000000) begin failures++; $display("FAIL round_pos_q got=%h exp=000000", tx_fe_q); end
    sample = {16'hFFDF, 16'hFFE0};
    for (int c = 0; c < 10; c++) step();
    checks++; if (tx_fe_i !== 24'hFFFFFF) begin failures++; $display("FAIL round_neg_i got=%h exp=ffffff", tx_fe_i); end
    checks++; if (tx_fe_q !== 24'h000000) begin failures++; $display("FAIL round_neg_q got=%h exp=000000", tx_fe_q); end
    stop_run();
  endtask

  task automatic test_saturation();
    logic [23:0] ei, eq;
    wr(SR_SWAP, 32'd1);
    wr(SR_SCALE, 32'h1FFFF);
    run = 1'b1; sample = 32'h7FFF_8000;
`ifdef DUC_SWAP_IQ_EN
    ei = 24'h800000; eq = 24'h7FFFFF;
`else
    ei = 24'h7FFFFF; eq = 24'h800000;
`endif
    for (int c = 0; c < 10; c++) step();
    checks++; if (tx_fe_i !== ei) begin failures++; $display("FAIL sat_a_i got=%h exp=%h", tx_fe_i, ei); end
    checks++; if (tx_fe_q !== eq) begin failures++; $display("FAIL sat_a_q got=%h exp=%h", tx_fe_q, eq); end
    sample = 32'h8000_7FFF;
    for (int c = 0; c < 10; c++) step();
    checks++; if (tx_fe_i !== eq) begin failures++; $display("FAIL sat_b_i got=%h exp=%h", tx_fe_i, eq); end
    checks++; if (tx_fe_q !== ei) begin failures++; $display("FAIL sat_b_q got=%h exp=%h", tx_fe_q, ei); end
    wr(SR_SWAP, 32'd0);
    stop_run();
  endtask

  task automatic test_nco();
    logic [23:0] e;
    wr(SR_PHASE_INC, 32'h4000_0000);
    run = 1'b1; sample = '0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (c < 7) e = 24'h0;
      else       e = 24'((c - 7) % 4) << 22;
      checks++; if (phase_out !== e) begin failures++; $display("FAIL nco c=%0d got=%h exp=%h", c, phase_out, e); end
      step();
    end
    stop_run();
    checks++; if (phase_out !== 24'h0) begin failures++; $display("FAIL nco_stop got=%h exp=000000", phase_out); end
  endtask

  task automatic test_reset_mid();
    wr(SR_RATE, 32'd8);
    wr(SR_SCALE, 32'(SCALE_ONE));
    run = 1'b1; sample = 32'h1000_1000;
    for (int c = 0; c <= 40; c++) begin
      if (c == 40) begin
        checks++; if (tx_fe_i !== 24'h100000) begin failures++; $display("FAIL r8_i got=%h exp=100000", tx_fe_i); end
        checks++; if (tx_fe_q !== 24'h100000) begin failures++; $display("FAIL r8_q got=%h exp=100000", tx_fe_q); end
      end
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL rstmid_strobe got=%b exp=0", strobe); end
    checks++; if (tx_fe_i !== 24'h0) begin failures++; $display("FAIL rstmid_i got=%h exp=000000", tx_fe_i); end
    checks++; if (tx_fe_q !== 24'h0) begin failures++; $display("FAIL rstmid_q got=%h exp=000000", tx_fe_q); end
    checks++; if (phase_out !== 24'h0) begin failures++; $display("FAIL rstmid_phase got=%h exp=000000", phase_out); end
    run = 1'b0; sample = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_clear();
    logic e;
    wr(SR_RATE, 32'd8);
    wr(SR_SCALE, 32'(SCALE_ONE));
    wr(SR_PHASE_INC, 32'h0000_0100);
    run = 1'b1; sample = 32'h1000_0000;
    for (int c = 0; c <= 40; c++) begin
      if (c == 40) begin
        checks++; if (tx_fe_i !== 24'h100000) begin failures++; $display("FAIL clr_pre_i got=%h exp=100000", tx_fe_i); end
        checks++; if (phase_out !== 24'd33) begin failures++; $display("FAIL clr_pre_phase got=%h exp=%h", phase_out, 24'd33); end
      end
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    checks++; if (tx_fe_i !== 24'h0) begin failures++; $display("FAIL clr_i got=%h exp=000000", tx_fe_i); end
    checks++; if (tx_fe_q !== 24'h0) begin failures++; $display("FAIL clr_q got=%h exp=000000", tx_fe_q); end
    checks++; if (phase_out !== 24'h0) begin failures++; $display("FAIL clr_phase got=%h exp=000000", phase_out); end
    checks++; if (strobe !== 1'b1) begin failures++; $display("FAIL clr_strobe got=%b exp=1", strobe); end
    step();
    for (int c = 1; c <= 48; c++) begin
      #1;
      e = (c % 8 == 0);
      checks++; if (strobe !== e) begin failures++; $display("FAIL clr_restart c=%0d got=%b exp=%b", c, strobe, e); end
      if (c == 48) begin
        checks++; if (tx_fe_i !== 24'h100000) begin failures++; $display("FAIL clr_post_i got=%h exp=100000", tx_fe_i); end
      end
      step();
    end
    stop_run();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_strober();
    test_impulse();
    test_step();
    test_rounding();
    test_saturation();
    test_nco();
    test_reset_mid();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/duc_chain.md
# duc_chain

Digital up-conversion chain for the TX path. Pulls 16-bit complex samples from TX control with a rate strobe, applies an 18-bit gain, interpolates with a 4-stage CIC, and drives WIDTH-bit I/Q to the TX frontend. It also exports a phase-aligned NCO phase word for the downstream CORDIC.

## Interface
- BASE, 0: settings-bus base address.
- WIDTH, 24: output sample width; legal range 18..24.
- clk  in  1: sample-rate clock.
- rst_n  in  1: asynchronous, active-low reset.
- clr  in  1: synchronous clear of datapath state and strobe counter. Settings are not cleared.
- set_stb  in  1: settings write strobe.
- set_addr  in  8: settings address.
- set_data  in  32: settings data.
- sample  in  32: I in [31:16], Q in [15:0], two's complement. Must be valid in every cycle where strobe=1.
- run  in  1: enables the chain.
- strobe  out  1: one-cycle pulse; sample is consumed in that cycle.
- tx_fe_i, tx_fe_q  out  WIDTH: interpolated I/Q, one value per clk.
- phase_out  out  24: NCO phase[31:8], aligned with tx_fe_i/q.

## Operation
- Settings registers, all reset to 0:
  - BASE+0: phase_inc[31:0].
  - BASE+1: scale[17:0], signed; 1.0 = 16384.
  - BASE+2: interp_rate[7:0]; values 0 and 1 both mean R=1.
- Strober:
  - Down-counter, reset to 0.
  - With run=1 and counter==0: strobe=1 and the counter reloads R-1. Otherwise the counter decrements.
  - The first strobe occurs in the first cycle run is high.
  - A change to interp_rate takes effect at the next reload.
- Scale stage, registered when strobe=1:
  - prod = I×scale (34b signed).
  - scaled = sat_WIDTH((prod + 2^(29−WIDTH)) >>> (30−WIDTH)).
  - Q is handled identically.
- CIC interpolator, N=4, internal width WIDTH+24:
  - The comb section runs on the delayed strobe.
  - The integrator input is the comb output in the cycle after the comb update, and zero otherwise (zero-stuffing).
  - Integrators run every cycle while run=1 and wrap modulo 2^(WIDTH+24).
- Gain normalisation:
  - Output = sat_WIDTH(integrator_out >>> 3·ceil(log2 R)).
  - Exact for power-of-two R. For other R the residual gain is compensated via scale.
- NCO:
  - phase <= 0 when run=0, else phase + phase_inc, wrapping mod 2^32.
  - phase_out is phase[31:8], delayed to match the datapath.
- run low or clr:
  - Next cycle: strobe=0, all comb/integrator/pipeline registers and the counter are 0, and tx_fe_i/q=0.
  - Phase resets to 0.
- Reset values: strobe=0, tx_fe_i/q=0, phase_out=0, all internal state 0.

## Timing
- Sample consumed at cycle T (strobe=1) produces its first contribution on tx_fe_i/q at T+7. The pipeline is:
  - scale register: 1 cycle
  - comb register: 1 cycle
  - 4 registered integrators: 4 cycles
  - output shift/saturate register: 1 cycle
- phase_out is delayed by the same 7 cycles relative to the phase accumulator.
- Strobe period is exactly R cycles while run=1, with no gaps.

## Configuration
- DUC_SWAP_IQ_EN defined:
  - Settings register BASE+3 bit0 (swap_iq, reset 0) exists.
  - When swap_iq=1, the I and Q halves of sample are exchanged before the scale stage. Latency is unchanged.
- DUC_SWAP_IQ_EN undefined: the register is absent, writes to BASE+3 are ignored, and there is never a swap.

## Structure
- Package duc_pkg holds:
  - setting offsets (SR_PHASE_INC=0, SR_SCALE=1, SR_RATE=2, SR_SWAP=3)
  - CIC_N=4 and CIC_GROWTH=24
  - SCALE_ONE=16384
  - function cic_shift(rate) returning 3·ceil(log2 R)
- Sub-module cic_interp: one real channel (combs, zero-stuff, integrators, shift/saturate). Instantiated twice (I, Q).

## Test plan
- Strober: interp_rate=5, raise run → strobe at run cycles 0, 5, 10, 15…; drop run → no strobe from the next cycle on.
- Impulse, R=1, scale=16384: sample I=0x1000 for one strobe then zeros → tx_fe_i=0x100000 for exactly one cycle at T+7, else 0; Q stays 0.
- Step, R=4, scale=16384: constant I=0x1000 → tx_fe_i settles to 0x100000, with strobe every 4 cycles.
- Saturation, R=1: scale=0x1FFFF, I=0x7FFF → tx_fe_i=0x7FFFFF; I=0x8000 → tx_fe_i=0x800000.
- NCO: phase_inc=0x40000000, run → phase_out sequence 0x000000, 0x400000, 0x800000, 0xC00000, 0x000000 (wrap). Deassert run → phase_out returns to 0.
- Reset/clear: assert rst_n low mid-stream with R=8 → all outputs 0 immediately. Pulse clr while running → tx_fe_i/q=0 next cycle, after which the counter restarts and strobe fires in the cycle following clr.
